// File: rtl/vc_port_controller.sv
// Virtual-channel input port controller.
// Each VC has its own flit FIFO and a small packet FSM. One round-robin
// arbiter asks the router to reserve an output port. A second round-robin
// arbiter forwards flits from VCs that hold a reservation. The reservation
// is released with a one-cycle relieve pulse after the packet's last flit.
module vc_port_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int VC            = 4,
  parameter int BUFFER_DEPTH  = 4,
  parameter int REQUEST_WIDTH = 2,
  localparam int VW           = $clog2(VC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic [VW-1:0]            vc_in,
  input  logic                     valid_in,
  output logic [VC-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [VW-1:0]            vc_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  output logic [VW-1:0]            routeReserveVC,
  input  logic                     routeReserveStatus,
  output logic                     routeRelieve,
  output logic [VW-1:0]            routeRelieveVC,
  output logic                     protocolError
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TYPE_WIDTH-1:0] TYPE_HEADTAIL = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD     = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL     = TYPE_WIDTH'(3);

  typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE} vcState_t;

  logic [DATA_WIDTH-1:0] mem [VC][BUFFER_DEPTH];
  logic [PW-1:0]         wrPtr [VC];
  logic [PW-1:0]         rdPtr [VC];
  logic [CW-1:0]         count [VC];
  logic [DATA_WIDTH-1:0] front [VC];
  logic [TYPE_WIDTH-1:0] frontType [VC];
  logic [VC-1:0]         notEmpty, pushVec, popVec, discardVec, outPopVec;

  vcState_t              stateQ [VC];
  vcState_t              stateD [VC];
  logic [VC-1:0]         headSentQ, headSentD;

  logic [VC-1:0]         reqCand, outCand;
  logic                  reqBusy, outBusy;
  logic [VW-1:0]         reqVcQ, outVcQ, reqPtr, outPtr, reqSel, outSel;
  logic                  reqValid, reqGrant, outValid, outFire;
  logic                  outIsHead, outIsEnd, errSet;

  function automatic logic isHead(input logic [TYPE_WIDTH-1:0] t);
    return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
  endfunction

  function automatic logic isEnd(input logic [TYPE_WIDTH-1:0] t);
    return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
  endfunction

  // First candidate at or after ptr, wrapping; VC is a power of two.
  function automatic logic [VW-1:0] rrPick(input logic [VC-1:0] cand,
                                           input logic [VW-1:0] ptr);
    logic [VW-1:0] idx;
    logic          found;
    rrPick = '0;
    found  = 1'b0;
    for (int i = 0; i < VC; i++) begin
      idx = ptr + VW'(i);
      if (!found && cand[idx]) begin
        rrPick = idx;
        found  = 1'b1;
      end
    end
  endfunction

  // FIFO front view, fullness and the push/discard decode per VC.
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      front[v]      = mem[v][rdPtr[v]];
      frontType[v]  = front[v][DATA_WIDTH-1 -: TYPE_WIDTH];
      notEmpty[v]   = (count[v] != '0);
      ready_in[v]   = (count[v] != CW'(BUFFER_DEPTH));
      pushVec[v]    = valid_in && ready_in[v] && (vc_in == VW'(v));
      reqCand[v]    = (stateQ[v] == REQUEST);
      outCand[v]    = (stateQ[v] == ACTIVE) && notEmpty[v];
      discardVec[v] = (stateQ[v] == IDLE) && notEmpty[v] && !isHead(frontType[v]);
    end
  end

  // Both arbiters: a held selection wins, otherwise round-robin pick.
  always_comb begin
    reqSel    = reqBusy ? reqVcQ : rrPick(reqCand, reqPtr);
    reqValid  = reqBusy || (|reqCand);
    reqGrant  = reqValid && routeReserveStatus;
    outSel    = outBusy ? outVcQ : rrPick(outCand, outPtr);
    outValid  = outBusy || (|outCand);
    outFire   = outValid && ready_out;
    outIsHead = isHead(frontType[outSel]);
    outIsEnd  = isEnd(frontType[outSel]);
    outPopVec = '0;
    for (int v = 0; v < VC; v++) begin
      outPopVec[v] = outFire && (outSel == VW'(v));
    end
    popVec = outPopVec | discardVec;
    errSet = (|discardVec) || (outFire && headSentQ[outSel] && outIsHead);
  end

  // Outputs are forced to zero whenever the matching valid is low.
  always_comb begin
    routeReserveRequestValid = reqValid;
    routeReserveVC           = reqValid ? reqSel : '0;
    routeReserveRequest      = reqValid ? front[reqSel][REQUEST_WIDTH-1:0] : '0;
    valid_out                = outValid;
    vc_out                   = outValid ? outSel : '0;
    data_out                 = outValid ? front[outSel] : '0;
  end

  // Per-VC packet FSM next state; headSent marks that the packet's head left.
  always_comb begin
    for (int v = 0; v < VC; v++) begin
      stateD[v]    = stateQ[v];
      headSentD[v] = headSentQ[v];
      case (stateQ[v])
        IDLE: begin
          headSentD[v] = 1'b0;
          if (notEmpty[v] && isHead(frontType[v])) stateD[v] = REQUEST;
        end
        REQUEST: begin
          if (reqGrant && (reqSel == VW'(v))) stateD[v] = ACTIVE;
        end
        ACTIVE: begin
          if (outPopVec[v]) begin
            if (isEnd(frontType[v])) begin
              stateD[v]    = IDLE;
              headSentD[v] = 1'b0;
            end else begin
              headSentD[v] = 1'b1;
            end
          end
        end
        default: stateD[v] = IDLE;
      endcase
    end
  end

  // FSM state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC; v++) stateQ[v] <= IDLE;
      headSentQ <= '0;
    end else begin
      for (int v = 0; v < VC; v++) stateQ[v] <= stateD[v];
      headSentQ <= headSentD;
    end
  end

  // FIFO pointers and occupancy; push and pop together keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < VC; v++) begin
        wrPtr[v] <= '0;
        rdPtr[v] <= '0;
        count[v] <= '0;
      end
    end else begin
      for (int v = 0; v < VC; v++) begin
        if (pushVec[v]) wrPtr[v] <= wrPtr[v] + PW'(1);
        if (popVec[v])  rdPtr[v] <= rdPtr[v] + PW'(1);
        if (pushVec[v] && !popVec[v])      count[v] <= count[v] + CW'(1);
        else if (!pushVec[v] && popVec[v]) count[v] <= count[v] - CW'(1);
      end
    end
  end

  // FIFO storage; contents are only observed through valid-gated outputs.
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC; v++) begin
      if (pushVec[v]) mem[v][wrPtr[v]] <= data_in;
    end
  end

  // Arbiter hold registers and round-robin pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reqBusy <= 1'b0;
      reqVcQ  <= '0;
      reqPtr  <= '0;
      outBusy <= 1'b0;
      outVcQ  <= '0;
      outPtr  <= '0;
    end else begin
      if (reqGrant) begin
        reqBusy <= 1'b0;
        reqPtr  <= reqSel + VW'(1);
      end else if (reqValid) begin
        reqBusy <= 1'b1;
        reqVcQ  <= reqSel;
      end
      if (outFire) begin
        outBusy <= 1'b0;
        outPtr  <= outSel + VW'(1);
      end else if (outValid) begin
        outBusy <= 1'b1;
        outVcQ  <= outSel;
      end
    end
  end

  // Relieve pulse follows the last flit's pop; the error flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      routeRelieve   <= 1'b0;
      routeRelieveVC <= '0;
      protocolError  <= 1'b0;
    end else begin
      routeRelieve   <= outFire && outIsEnd;
      routeRelieveVC <= (outFire && outIsEnd) ? outSel : '0;
      if (errSet) protocolError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_port_controller.sv
// Directed testbench for vc_port_controller with default parameters.
module tb_vc_port_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [1:0]  vc_in = '0;
  logic        valid_in = 1'b0;
  logic [3:0]  ready_in;
  logic [31:0] data_out;
  logic [1:0]  vc_out;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic        routeReserveRequestValid;
  logic [1:0]  routeReserveRequest;
  logic [1:0]  routeReserveVC;
  logic        routeReserveStatus = 1'b0;
  logic        routeRelieve;
  logic [1:0]  routeRelieveVC;
  logic        protocolError;

  int numVectors = 0;
  int numMiscompares = 0;

  vc_port_controller dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .vc_in(vc_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .vc_out(vc_out), .valid_out(valid_out), .ready_out(ready_out),
    .routeReserveRequestValid(routeReserveRequestValid),
    .routeReserveRequest(routeReserveRequest),
    .routeReserveVC(routeReserveVC),
    .routeReserveStatus(routeReserveStatus),
    .routeRelieve(routeRelieve), .routeRelieveVC(routeRelieveVC),
    .protocolError(protocolError)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyReset();
    rst = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    vc_in = '0;
    ready_out = 1'b0;
    routeReserveStatus = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    numVectors++;
    if ({valid_out, routeReserveRequestValid, routeRelieve, protocolError} !== 4'b0000) begin
      numMiscompares++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {valid_out, routeReserveRequestValid, routeRelieve, protocolError});
    end
    numVectors++;
    if ({data_out, vc_out, routeReserveRequest, routeReserveVC, routeRelieveVC} !== 40'h0) begin
      numMiscompares++;
      $display("[TB] FAIL reset_fields: got %h want 0", {data_out, vc_out, routeReserveRequest, routeReserveVC, routeRelieveVC});
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    numVectors++;
    if (ready_in !== 4'hF) begin
      numMiscompares++;
      $display("[TB] FAIL reset_ready_in: got %h want f", ready_in);
    end
  endtask

  task automatic test_headtail();
    applyReset();
    ready_out = 1'b1;
    data_in = 32'h0000_0002; vc_in = 2'd1; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    numVectors++;
    if (routeReserveRequestValid !== 1'b0) begin
      numMiscompares++;
      $display("[TB] FAIL ht_no_early_req: got %b want 0", routeReserveRequestValid);
    end
    tick();
    numVectors++;
    if ({routeReserveRequestValid, routeReserveRequest, routeReserveVC, valid_out} !== {1'b1, 2'd2, 2'd1, 1'b0}) begin
      numMiscompares++;
      $display("[TB] FAIL ht_request: got %b want 110010", {routeReserveRequestValid, routeReserveRequest, routeReserveVC, valid_out});
    end
    routeReserveStatus = 1'b1;
    tick();
    routeReserveStatus = 1'b0;
    numVectors++;
    if ({valid_out, data_out, vc_out} !== {1'b1, 32'h0000_0002, 2'd1}) begin
      numMiscompares++;
      $display("[TB] FAIL ht_output: got %b %h %0d want 1 00000002 1", valid_out, data_out, vc_out);
    end
    tick();
    numVectors++;
    if ({routeRelieve, routeRelieveVC, valid_out} !== {1'b1, 2'd1, 1'b0}) begin
      numMiscompares++;
      $display("[TB] FAIL ht_relieve: got %b %0d %b want 1 1 0", routeRelieve, routeRelieveVC, valid_out);
    end
    tick();
    numVectors++;
    if (routeRelieve !== 1'b0) begin
      numMiscompares++;
      $display("[TB] FAIL ht_relieve_width: got %b want 0", routeRelieve);
    end
  endtask

  task automatic test_hold();
    logic [31:0] expFlit [3];
    int relieveCount;
    expFlit[0] = 32'h4000_0001;
    expFlit[1] = 32'h8000_00AA;
    expFlit[2] = 32'hC000_00BB;
    relieveCount = 0;
    applyReset();
    routeReserveStatus = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_in = expFlit[k]; vc_in = 2'd0; valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (routeRelieve === 1'b1) relieveCount++;
      numVectors++;
      if ({valid_out, data_out, vc_out} !== {1'b1, expFlit[0], 2'd0}) begin
        numMiscompares++;
        $display("[TB] FAIL hold_stable%0d: got %b %h %0d want 1 %h 0", k, valid_out, data_out, vc_out, expFlit[0]);
      end
      if (k < 2) tick();
    end
    ready_out = 1'b1;
    tick();
    for (int k = 1; k < 3; k++) begin
      if (routeRelieve === 1'b1) relieveCount++;
      numVectors++;
      if ({valid_out, data_out} !== {1'b1, expFlit[k]}) begin
        numMiscompares++;
        $display("[TB] FAIL hold_order%0d: got %b %h want 1 %h", k, valid_out, data_out, expFlit[k]);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (routeRelieve === 1'b1) relieveCount++;
      tick();
    end
    routeReserveStatus = 1'b0;
    numVectors++;
    if (relieveCount !== 1) begin
      numMiscompares++;
      $display("[TB] FAIL hold_relieve_count: got %0d want 1", relieveCount);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] expData [8];
    logic [1:0]  expVc [8];
    int relieveCount;
    relieveCount = 0;
    for (int v = 0; v < 4; v++) begin
      expData[v]     = 32'h4000_0000 | (v << 4) | v;
      expData[v + 4] = 32'hC000_00F0 | v;
      expVc[v]       = 2'(v);
      expVc[v + 4]   = 2'(v);
    end
    applyReset();
    for (int k = 0; k < 8; k++) begin
      data_in = expData[k]; vc_in = expVc[k]; valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    routeReserveStatus = 1'b1;
    for (int k = 0; k < 4; k++) begin
      numVectors++;
      if ({routeReserveRequestValid, routeReserveVC, routeReserveRequest} !== {1'b1, 2'(k), 2'(k)}) begin
        numMiscompares++;
        $display("[TB] FAIL rr_grant%0d: got %b vc%0d req%0d want vc%0d req%0d", k, routeReserveRequestValid, routeReserveVC, routeReserveRequest, k, k);
      end
      tick();
    end
    routeReserveStatus = 1'b0;
    ready_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      numVectors++;
      if ({valid_out, data_out, vc_out} !== {1'b1, expData[k], expVc[k]}) begin
        numMiscompares++;
        $display("[TB] FAIL rr_out%0d: got %b %h %0d want 1 %h %0d", k, valid_out, data_out, vc_out, expData[k], expVc[k]);
      end
      tick();
      if (routeRelieve === 1'b1) relieveCount++;
    end
    numVectors++;
    if ({valid_out, relieveCount} !== {1'b0, 32'd4}) begin
      numMiscompares++;
      $display("[TB] FAIL rr_drain: got valid %b relieves %0d want 0 4", valid_out, relieveCount);
    end
  endtask

  task automatic test_full();
    logic [31:0] flit [4];
    flit[0] = 32'h4000_0002;
    flit[1] = 32'h8000_0021;
    flit[2] = 32'h8000_0022;
    flit[3] = 32'hC000_0023;
    applyReset();
    for (int k = 0; k < 4; k++) begin
      data_in = flit[k]; vc_in = 2'd2; valid_in = 1'b1;
      tick();
    end
    numVectors++;
    if (ready_in !== 4'b1011) begin
      numMiscompares++;
      $display("[TB] FAIL full_ready_in: got %b want 1011", ready_in);
    end
    data_in = 32'h8000_0055;
    tick();
    valid_in = 1'b0;
    numVectors++;
    if (ready_in !== 4'b1011) begin
      numMiscompares++;
      $display("[TB] FAIL full_fifth_rejected: got %b want 1011", ready_in);
    end
    routeReserveStatus = 1'b1;
    ready_out = 1'b1;
    tick();
    routeReserveStatus = 1'b0;
    for (int k = 0; k < 4; k++) begin
      numVectors++;
      if ({valid_out, data_out, vc_out} !== {1'b1, flit[k], 2'd2}) begin
        numMiscompares++;
        $display("[TB] FAIL full_drain%0d: got %b %h %0d want 1 %h 2", k, valid_out, data_out, vc_out, flit[k]);
      end
      tick();
    end
    tick();
    numVectors++;
    if ({valid_out, protocolError, ready_in} !== {1'b0, 1'b0, 4'hF}) begin
      numMiscompares++;
      $display("[TB] FAIL full_empty_after: got %b %b %h want 0 0 f", valid_out, protocolError, ready_in);
    end
  endtask

  task automatic test_stray_body();
    applyReset();
    data_in = 32'h8000_0003; vc_in = 2'd3; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    numVectors++;
    if ({protocolError, routeReserveRequestValid, ready_in} !== {1'b1, 1'b0, 4'hF}) begin
      numMiscompares++;
      $display("[TB] FAIL stray_discard: got %b %b %h want 1 0 f", protocolError, routeReserveRequestValid, ready_in);
    end
    tick();
    tick();
    tick();
    numVectors++;
    if ({protocolError, routeReserveRequestValid, valid_out} !== 3'b100) begin
      numMiscompares++;
      $display("[TB] FAIL stray_sticky: got %b want 100", {protocolError, routeReserveRequestValid, valid_out});
    end
    applyReset();
    numVectors++;
    if (protocolError !== 1'b0) begin
      numMiscompares++;
      $display("[TB] FAIL stray_cleared: got %b want 0", protocolError);
    end
  endtask

  task automatic test_reset_mid_packet();
    int relieveCount;
    relieveCount = 0;
    applyReset();
    routeReserveStatus = 1'b1;
    data_in = 32'h4000_0003; vc_in = 2'd0; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    numVectors++;
    if ({valid_out, data_out} !== {1'b1, 32'h4000_0003}) begin
      numMiscompares++;
      $display("[TB] FAIL mid_active: got %b %h want 1 40000003", valid_out, data_out);
    end
    #2 rst = 1'b0;
    #1;
    numVectors++;
    if ({valid_out, data_out, vc_out, routeReserveRequestValid, routeRelieve, protocolError} !== 38'h0) begin
      numMiscompares++;
      $display("[TB] FAIL mid_async_clear: got %b %h %0d %b %b %b want all 0", valid_out, data_out, vc_out, routeReserveRequestValid, routeRelieve, protocolError);
    end
    routeReserveStatus = 1'b0;
    tick();
    rst = 1'b1;
    ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (routeRelieve === 1'b1) relieveCount++;
    end
    numVectors++;
    if ({relieveCount, valid_out} !== {32'd0, 1'b0}) begin
      numMiscompares++;
      $display("[TB] FAIL mid_no_relieve: got %0d relieves valid %b want 0 0", relieveCount, valid_out);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_headtail();
    test_hold();
    test_round_robin();
    test_full();
    test_stray_body();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/vc_port_controller.md
VC_PORT_CONTROLLER -- requirements
Module: vc_port_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter TYPE_WIDTH, default 2, flit-type field at data_in[DATA_WIDTH-1 -: TYPE_WIDTH].
REQ-003 SHALL have parameter VC, default 4, number of virtual channels (power of 2, >=2); VW = $clog2(VC).
REQ-004 SHALL have parameter BUFFER_DEPTH, default 4, flits per VC FIFO (power of 2, >=2).
REQ-005 SHALL have parameter REQUEST_WIDTH, default 2, output-port request field at head flit data_in[REQUEST_WIDTH-1:0].
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: data_in in DATA_WIDTH; vc_in in VW; valid_in in 1; ready_in out VC (per-VC not-full).
REQ-008 SHALL have ports: data_out out DATA_WIDTH; vc_out out VW; valid_out out 1; ready_out in 1.
REQ-009 SHALL have ports: routeReserveRequestValid out 1; routeReserveRequest out REQUEST_WIDTH; routeReserveVC out VW; routeReserveStatus in 1 (grant).
REQ-010 SHALL have ports: routeRelieve out 1 (pulse); routeRelieveVC out VW; protocolError out 1 (sticky).

Function
REQ-011 Type encoding SHALL be 01 HEAD, 10 BODY, 11 TAIL, 00 HEADTAIL (single-flit packet).
REQ-012 Input handshake SHALL occur when valid_in && ready_in[vc_in]; flit pushed into FIFO vc_in at that edge.
REQ-013 ready_in[v] SHALL be !full[v]; no bypass, so a full FIFO does not accept even when popped in the same cycle.
REQ-014 Each VC SHALL run FSM IDLE -> REQUEST -> ACTIVE -> IDLE, registered.
REQ-015 IDLE: FIFO front HEAD/HEADTAIL SHALL go to REQUEST; front BODY/TAIL SHALL be popped and discarded, protocolError set; empty FIFO stays IDLE.
REQ-016 Request arbiter SHALL pick one REQUEST VC round-robin (priority after last granted VC) and drive routeReserveRequestValid=1, routeReserveVC, routeReserveRequest = front flit[REQUEST_WIDTH-1:0].
REQ-017 Selected request SHALL be held stable until routeReserveStatus=1 is sampled; that VC goes to ACTIVE at that edge and the pointer advances.
REQ-018 Output arbiter SHALL pick round-robin among ACTIVE VCs with non-empty FIFO; valid_out=1, data_out/vc_out from that FIFO front.
REQ-019 Once valid_out=1, the selection and data_out/vc_out SHALL be held until ready_out=1 (no retraction).
REQ-020 Pop SHALL occur on valid_out && ready_out; flit-level interleaving across VCs is allowed.
REQ-021 Popping TAIL/HEADTAIL SHALL return the VC to IDLE and, one cycle later, pulse routeRelieve=1 for exactly one cycle with routeRelieveVC = that VC.
REQ-022 HEAD/HEADTAIL popped while ACTIVE (missing tail) SHALL set protocolError and be forwarded.
REQ-023 Minimum latency SHALL be: push at edge t, REQUEST after edge t+1, grant sampled at edge t+2 -> valid_out after edge t+2.
REQ-024 Simultaneous push and pop on one VC SHALL leave its count unchanged; pointers wrap modulo BUFFER_DEPTH.
REQ-025 Output SHALL stay combinationally independent of valid_in (no input-to-output path).

Reset
REQ-026 rst=0 SHALL asynchronously clear all FIFOs, pointers, FSMs (IDLE) and arbiter pointers (VC0 highest priority).
REQ-027 During reset: ready_in=all 1 after release only; valid_out, routeReserveRequestValid, routeRelieve, protocolError = 0; data_out, vc_out, routeReserveRequest, routeReserveVC, routeRelieveVC = 0.
REQ-028 Reset mid-packet SHALL drop in-flight flits without emitting routeRelieve.

Verification
REQ-029 HEADTAIL 0x0000_0002 on VC1, grant next cycle -> request=2, routeReserveVC=1; data_out=0x0000_0002, vc_out=1; routeRelieve pulse, routeRelieveVC=1.
REQ-030 HEAD/BODY/TAIL on VC0 with ready_out held 0 for 3 cycles -> data_out/vc_out stable; 3 flits out in order; one routeRelieve.
REQ-031 Heads on VC0..VC3 same cycle set, grants every cycle -> routeReserveVC sequence 0,1,2,3; outputs interleaved round-robin.
REQ-032 Push 4 flits to VC2 with ready_out=0 -> ready_in[2]=0, other bits 1; 5th flit not accepted.
REQ-033 BODY flit on idle VC3 -> discarded, protocolError=1 until reset, no request.
REQ-034 rst low during ACTIVE packet on VC0 -> all outputs 0 immediately; no routeRelieve after release.
